// File: rtl/md_sb_pkg.sv
// Shared definitions for the multdiv issue/hazard scoreboard.
// Holds the FSM state encoding and the default register-file constants.
package md_sb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] RSTATUS_ADDR = 5'd30;
  localparam int TIMEOUT_CYCLES = 40;
  localparam int TIMEOUT_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_scoreboard_if.sv
// Bundle between the pipeline/multdiv unit (master) and the scoreboard (slave).
interface multdiv_scoreboard_if;
  import md_sb_pkg::*;

  logic                  issue_valid;
  logic                  issue_is_div;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] dec_src_a;
  logic [REG_ADDR_W-1:0] dec_src_b;
  logic                  dec_src_a_used;
  logic                  dec_src_b_used;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_rd_we;
  logic                  md_result_rdy;
  logic                  md_exception;
  logic                  md_ctrl_mult;
  logic                  md_ctrl_div;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic                  pend_rd_we;
  logic                  busy;
  logic                  stall;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_exception;
  logic                  timeout;

  modport master (
    output issue_valid, issue_is_div, issue_rd,
    output dec_src_a, dec_src_b, dec_src_a_used, dec_src_b_used, dec_rd, dec_rd_we,
    output md_result_rdy, md_exception,
    input  md_ctrl_mult, md_ctrl_div, pend_rd, pend_rd_we, busy, stall,
    input  wb_valid, wb_rd, wb_exception, timeout
  );

  modport slave (
    input  issue_valid, issue_is_div, issue_rd,
    input  dec_src_a, dec_src_b, dec_src_a_used, dec_src_b_used, dec_rd, dec_rd_we,
    input  md_result_rdy, md_exception,
    output md_ctrl_mult, md_ctrl_div, pend_rd, pend_rd_we, busy, stall,
    output wb_valid, wb_rd, wb_exception, timeout
  );

endinterface

// File: rtl/md_hazard_cmp.sv
// Compares the decode-stage source/destination registers against the pending
// multdiv destination; register 0 never creates a hazard.
module md_hazard_cmp
  import md_sb_pkg::*;
#(
  parameter int W = md_sb_pkg::REG_ADDR_W
) (
  input  logic [W-1:0] pend_rd,
  input  logic [W-1:0] src_a,
  input  logic         src_a_used,
  input  logic [W-1:0] src_b,
  input  logic         src_b_used,
  input  logic [W-1:0] dst,
  input  logic         dst_we,
  output logic         hazard
);

  logic pend_nonzero;
  logic raw_a;
  logic raw_b;
  logic waw;

  always_comb begin
    pend_nonzero = |pend_rd;
    raw_a        = src_a_used && (src_a == pend_rd);
    raw_b        = src_b_used && (src_b == pend_rd);
    waw          = dst_we && (dst == pend_rd);
    hazard       = pend_nonzero && (raw_a || raw_b || waw);
  end

endmodule

// File: rtl/multdiv_scoreboard.sv
// Issue/hazard controller for the multi-cycle multdiv unit.
// Optional watchdog on the BUSY wait is enabled with `define MD_TIMEOUT_EN.
module multdiv_scoreboard
  import md_sb_pkg::*;
#(
  parameter int                    REG_ADDR_W   = md_sb_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] RSTATUS_ADDR = md_sb_pkg::RSTATUS_ADDR
`ifdef MD_TIMEOUT_EN
  , parameter int                  TIMEOUT_CYCLES = md_sb_pkg::TIMEOUT_CYCLES
`endif
) (
  input logic                 clock,
  input logic                 ctrl_reset_n,
  multdiv_scoreboard_if.slave md
);

  md_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic                  md_mult_q, md_mult_d;
  logic                  md_div_q, md_div_d;
  logic                  busy_q, busy_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_exc_q, wb_exc_d;
  logic                  pend_we;
  logic                  accept;
  logic                  complete;
  logic                  hazard;
  logic                  in_flight;
`ifdef MD_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     expire;
`endif

  md_hazard_cmp #(
    .W(REG_ADDR_W)
  ) u_hazard (
    .pend_rd    (pend_rd_q),
    .src_a      (md.dec_src_a),
    .src_a_used (md.dec_src_a_used),
    .src_b      (md.dec_src_b),
    .src_b_used (md.dec_src_b_used),
    .dst        (md.dec_rd),
    .dst_we     (md.dec_rd_we),
    .hazard     (hazard)
  );

  // Accept wins over everything in IDLE/WB; completion only matters while in flight.
  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    md_mult_d  = 1'b0;
    md_div_d   = 1'b0;
    busy_d     = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_exc_d   = 1'b0;
    pend_we    = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    in_flight  = (state_q == ST_START) || (state_q == ST_BUSY);
`ifdef MD_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    expire     = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE, ST_WB: accept = md.issue_valid;
      ST_START:       complete = md.md_result_rdy;
      ST_BUSY: begin
        complete = md.md_result_rdy;
`ifdef MD_TIMEOUT_EN
        expire = !md.md_result_rdy && (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));
`endif
      end
      default: ;
    endcase

    if (accept) begin
      state_d   = ST_START;
      pend_we   = 1'b1;
      pend_rd_d = md.issue_rd;
      md_mult_d = !md.issue_is_div;
      md_div_d  = md.issue_is_div;
      busy_d    = 1'b1;
`ifdef MD_TIMEOUT_EN
      cnt_d     = '0;
`endif
    end else if (complete) begin
      state_d    = ST_WB;
      wb_valid_d = 1'b1;
      wb_exc_d   = md.md_exception;
      wb_rd_d    = md.md_exception ? RSTATUS_ADDR : pend_rd_q;
`ifdef MD_TIMEOUT_EN
    end else if (expire) begin
      state_d    = ST_WB;
      wb_valid_d = 1'b1;
      wb_exc_d   = 1'b1;
      wb_rd_d    = RSTATUS_ADDR;
      timeout_d  = 1'b1;
`endif
    end else if (in_flight) begin
      state_d = ST_BUSY;
      busy_d  = 1'b1;
`ifdef MD_TIMEOUT_EN
      if (state_q == ST_BUSY) begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end else if (state_q == ST_WB) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q    <= ST_IDLE;
      pend_rd_q  <= '0;
      md_mult_q  <= 1'b0;
      md_div_q   <= 1'b0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      md_mult_q  <= md_mult_d;
      md_div_q   <= md_div_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

`ifdef MD_TIMEOUT_EN
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign md.timeout = timeout_q;
`else
  assign md.timeout = 1'b0;
`endif

  // Structural conflicts stall even when the pending destination is r0.
  assign md.stall        = in_flight && (md.issue_valid || hazard);
  assign md.pend_rd_we   = pend_we && ctrl_reset_n;
  assign md.pend_rd      = pend_rd_q;
  assign md.md_ctrl_mult = md_mult_q;
  assign md.md_ctrl_div  = md_div_q;
  assign md.busy         = busy_q;
  assign md.wb_valid     = wb_valid_q;
  assign md.wb_rd        = wb_rd_q;
  assign md.wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_scoreboard.sv
// Directed self-checking bench for multdiv_scoreboard; the watchdog scenario
// runs only when MD_TIMEOUT_EN is defined.
module tb_multdiv_scoreboard;
  import md_sb_pkg::*;

  logic clock;
  logic ctrl_reset_n;
  int   assertions;
  int   failures;
  int   busy_cycles;
  int   mult_pulses;
  int   wb_seen;
  int   wb_cycle;

  multdiv_scoreboard_if md_if ();

  multdiv_scoreboard dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .md           (md_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic is_div, input logic [4:0] rd,
                               input logic rdy, input logic exc);
    md_if.issue_valid   = valid;
    md_if.issue_is_div  = is_div;
    md_if.issue_rd      = rd;
    md_if.md_result_rdy = rdy;
    md_if.md_exception  = exc;
    #1;
  endtask

  task automatic setDecode(input logic [4:0] a, input logic a_used, input logic [4:0] b,
                           input logic b_used, input logic [4:0] rd, input logic rd_we);
    md_if.dec_src_a      = a;
    md_if.dec_src_a_used = a_used;
    md_if.dec_src_b      = b;
    md_if.dec_src_b_used = b_used;
    md_if.dec_rd         = rd;
    md_if.dec_rd_we      = rd_we;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    assertions   = 0;
    failures     = 0;
    ctrl_reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    setDecode(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #10;

    $display("[TB] reset state");
    checkOutput("rst_busy", md_if.busy, 0);
    checkOutput("rst_stall", md_if.stall, 0);
    checkOutput("rst_wb_valid", md_if.wb_valid, 0);
    checkOutput("rst_mult", md_if.md_ctrl_mult, 0);
    checkOutput("rst_div", md_if.md_ctrl_div, 0);
    checkOutput("rst_pend_rd", md_if.pend_rd, 0);
    checkOutput("rst_pend_we", md_if.pend_rd_we, 0);
    checkOutput("rst_timeout", md_if.timeout, 0);
    ctrl_reset_n = 1'b1;
    tick();

    $display("[TB] mult rd=5, result 17 cycles after START");
    applyStimulus(1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    checkOutput("mul_pend_we", md_if.pend_rd_we, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mul_start_mult", md_if.md_ctrl_mult, 1);
    checkOutput("mul_start_div", md_if.md_ctrl_div, 0);
    checkOutput("mul_pend_rd", md_if.pend_rd, 5);
    checkOutput("mul_start_stall", md_if.stall, 0);
    busy_cycles = int'(md_if.busy);
    mult_pulses = int'(md_if.md_ctrl_mult);
    wb_seen     = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      busy_cycles += int'(md_if.busy);
      mult_pulses += int'(md_if.md_ctrl_mult);
      wb_seen     += int'(md_if.wb_valid);
      if (i == 17) applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mul_busy_cycles", busy_cycles, 18);
    checkOutput("mul_pulses", mult_pulses, 1);
    checkOutput("mul_wb_early", wb_seen, 0);
    checkOutput("mul_wb_valid", md_if.wb_valid, 1);
    checkOutput("mul_wb_rd", md_if.wb_rd, 5);
    checkOutput("mul_wb_exc", md_if.wb_exception, 0);
    checkOutput("mul_wb_busy", md_if.busy, 0);
    tick();
    checkOutput("mul_wb_one_cycle", md_if.wb_valid, 0);

    $display("[TB] reset in the middle of BUSY");
    applyStimulus(1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (5) tick();
    setDecode(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("rstmid_pre_stall", md_if.stall, 1);
    ctrl_reset_n = 1'b0;
    #1;
    checkOutput("rstmid_busy", md_if.busy, 0);
    checkOutput("rstmid_pend_rd", md_if.pend_rd, 0);
    checkOutput("rstmid_stall", md_if.stall, 0);
    tick();
    ctrl_reset_n = 1'b1;
    setDecode(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    wb_seen = 0;
    repeat (3) begin
      tick();
      wb_seen += int'(md_if.wb_valid);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("rstmid_no_wb", wb_seen, 0);
    checkOutput("rstmid_idle_busy", md_if.busy, 0);

    $display("[TB] div rd=9 with decode hazards");
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("div_start_div", md_if.md_ctrl_div, 1);
    checkOutput("div_start_mult", md_if.md_ctrl_mult, 0);
    setDecode(5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("div_a_unused", md_if.stall, 0);
    setDecode(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    checkOutput("div_raw_b_start", md_if.stall, 1);
    tick();
    checkOutput("div_raw_b_busy", md_if.stall, 1);
    checkOutput("div_pulse_gone", md_if.md_ctrl_div, 0);
    setDecode(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    checkOutput("div_waw", md_if.stall, 1);
    setDecode(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
    checkOutput("div_rd_no_we", md_if.stall, 0);
    setDecode(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("div_wb_stall", md_if.stall, 0);
    checkOutput("div_wb_valid", md_if.wb_valid, 1);
    checkOutput("div_wb_rd", md_if.wb_rd, 9);
    setDecode(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();

    $display("[TB] div with exception");
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("exc_wb_valid", md_if.wb_valid, 1);
    checkOutput("exc_wb_rd", md_if.wb_rd, 30);
    checkOutput("exc_wb_exc", md_if.wb_exception, 1);
    tick();
    checkOutput("exc_clear", md_if.wb_exception, 0);

    $display("[TB] mult rd=0 never hazards");
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    setDecode(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    checkOutput("r0_start_stall", md_if.stall, 0);
    tick();
    checkOutput("r0_busy_stall", md_if.stall, 0);
    applyStimulus(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
    checkOutput("r0_struct_stall", md_if.stall, 1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("r0_wb_valid", md_if.wb_valid, 1);
    checkOutput("r0_wb_rd", md_if.wb_rd, 0);
    setDecode(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();

    $display("[TB] back-to-back issue");
    applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    checkOutput("b2b_busy_stall", md_if.stall, 1);
    checkOutput("b2b_busy_no_load", md_if.pend_rd_we, 0);
    applyStimulus(1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    checkOutput("b2b_wb_valid", md_if.wb_valid, 1);
    checkOutput("b2b_wb_rd", md_if.wb_rd, 4);
    checkOutput("b2b_wb_stall", md_if.stall, 0);
    checkOutput("b2b_wb_load", md_if.pend_rd_we, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("b2b_start_div", md_if.md_ctrl_div, 1);
    checkOutput("b2b_pend_rd", md_if.pend_rd, 12);
    checkOutput("b2b_busy", md_if.busy, 1);
    checkOutput("b2b_wb_gone", md_if.wb_valid, 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("b2b_second_wb_rd", md_if.wb_rd, 12);
    tick();

`ifdef MD_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    applyStimulus(1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    wb_cycle = -1;
    for (int i = 1; i <= 60 && wb_cycle < 0; i++) begin
      tick();
      if (md_if.wb_valid) begin
        wb_cycle = i;
        checkOutput("to_wb_rd", md_if.wb_rd, 30);
        checkOutput("to_wb_exc", md_if.wb_exception, 1);
        checkOutput("to_flag", md_if.timeout, 1);
      end
    end
    checkOutput("to_wb_cycle", wb_cycle, 41);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("to_late_rdy_wb", md_if.wb_valid, 0);
    checkOutput("to_sticky", md_if.timeout, 1);
    checkOutput("to_idle_busy", md_if.busy, 0);
`else
    $display("[TB] long wait without watchdog");
    applyStimulus(1'b1, 1'b0, 5'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    wb_seen = 0;
    repeat (50) begin
      tick();
      wb_seen += int'(md_if.wb_valid);
    end
    checkOutput("nto_no_wb", wb_seen, 0);
    checkOutput("nto_busy", md_if.busy, 1);
    checkOutput("nto_timeout", md_if.timeout, 0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("nto_wb_valid", md_if.wb_valid, 1);
    checkOutput("nto_wb_rd", md_if.wb_rd, 2);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
